// File: rtl/mdu_pkg.sv
// Shared encodings and default latencies for the multiply/divide unit.
// Latency: n/a (package).
// Backpressure: n/a (package); also used by the decoder's md_ctr generation.
package mdu_pkg;

    // md_ctr command encodings
    typedef enum logic [2:0] {
        MD_MULT  = 3'b000,
        MD_MULTU = 3'b001,
        MD_DIV   = 3'b010,
        MD_DIVU  = 3'b011,
        MD_MTHI  = 3'b100,
        MD_MTLO  = 3'b101
    } md_ctr_e;

    // Unit state
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mdu_state_e;

    // Default latencies (busy cycles)
    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;
    // Iterative divider: one load cycle plus one cycle per quotient bit
    localparam int ITER_DIV_CYCLES = 33;

    // Width of the busy-cycle down-counter
    localparam int CNT_W = 8;

endpackage

// File: rtl/mdu_div_seq.sv
// Radix-2 restoring divider on operand magnitudes, sign fix-up on outputs.
// Latency: operands load on go, 32 iterations follow, done after the 32nd.
// Backpressure: none; caller must hold off a new go until done.
//
// Ports: clk, reset_n (sync, active-low); go loads dividend/divisor and the
// signed_op flag; done high when idle/finished; quot/rem are the signed-
// corrected results. Compiled only when MDU_ITERATIVE_DIV_EN is defined.
`ifdef MDU_ITERATIVE_DIV_EN
module mdu_div_seq (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        go,
    input  logic        signed_op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        done,
    output logic [31:0] quot,
    output logic [31:0] rem
);

    logic [31:0] rem_q,  rem_d;
    logic [31:0] quot_q, quot_d;
    logic [31:0] dvs_q,  dvs_d;
    logic [5:0]  iter_q, iter_d;
    logic        neg_q_q, neg_q_d;
    logic        neg_r_q, neg_r_d;

    logic [32:0] rem_sh;
    logic [33:0] diff;

    always_comb begin
        rem_d   = rem_q;
        quot_d  = quot_q;
        dvs_d   = dvs_q;
        iter_d  = iter_q;
        neg_q_d = neg_q_q;
        neg_r_d = neg_r_q;
        // Shift in the next dividend bit and trial-subtract the divisor
        rem_sh  = {rem_q, quot_q[31]};
        diff    = {1'b0, rem_sh} - {2'b00, dvs_q};

        if (go) begin
            rem_d   = 32'd0;
            quot_d  = (signed_op && dividend[31]) ? (32'd0 - dividend) : dividend;
            dvs_d   = (signed_op && divisor[31])  ? (32'd0 - divisor)  : divisor;
            iter_d  = 6'd32;
            neg_q_d = signed_op && (dividend[31] ^ divisor[31]);
            neg_r_d = signed_op && dividend[31];
        end else if (iter_q != 6'd0) begin
            iter_d = iter_q - 6'd1;
            if (!diff[33]) begin
                rem_d  = diff[31:0];
                quot_d = {quot_q[30:0], 1'b1};
            end else begin
                rem_d  = rem_sh[31:0];
                quot_d = {quot_q[30:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rem_q   <= 32'd0;
            quot_q  <= 32'd0;
            dvs_q   <= 32'd0;
            iter_q  <= 6'd0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
        end else begin
            rem_q   <= rem_d;
            quot_q  <= quot_d;
            dvs_q   <= dvs_d;
            iter_q  <= iter_d;
            neg_q_q <= neg_q_d;
            neg_r_q <= neg_r_d;
        end
    end

    assign done = (iter_q == 6'd0);
    // 0x80000000 / -1 falls out naturally: magnitude 2^31 negates to itself
    assign quot = neg_q_q ? (32'd0 - quot_q) : quot_q;
    assign rem  = neg_r_q ? (32'd0 - rem_q)  : rem_q;

endmodule
`endif

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers.
// Latency: MULT_CYCLES busy for mult, DIV_CYCLES (or 33 with MDU_ITERATIVE_DIV_EN) for div.
// Backpressure: busy/stall_md hold off later HI/LO users; commands while busy are dropped.
//
// Ports: clk, reset_n (sync, active-low); start/en_md/md_ctr/cancel command
// inputs; op_a/op_b operands; busy (registered), stall_md (combinational),
// hi/lo architectural registers.
// Build option: MDU_ITERATIVE_DIV_EN selects the bit-serial divider.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        en_md,
    input  logic [2:0]  md_ctr,
    input  logic        cancel,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo
);

`ifdef MDU_ITERATIVE_DIV_EN
    localparam int DIV_LAT = ITER_DIV_CYCLES;
`else
    localparam int DIV_LAT = DIV_CYCLES;
`endif

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [2:0]       ctr_q,   ctr_d;
    logic [31:0]      a_q,     a_d;
    logic [31:0]      b_q,     b_d;
    logic [31:0]      hi_q,    hi_d;
    logic [31:0]      lo_q,    lo_d;

    logic        accept;
    logic        start_acc;
    logic        mthi_acc;
    logic        mtlo_acc;
    logic [63:0] ext_a, ext_b, prod;
    logic        mul_sgn;
    logic [31:0] div_quot, div_rem;
    logic        div_done;

    // Only IDLE accepts anything; a cancelled command never touches state.
    assign accept    = en_md && !cancel && (state_q == IDLE);
    assign start_acc = accept && start && !md_ctr[2];
    assign mthi_acc  = accept && !start && (md_ctr == MD_MTHI);
    assign mtlo_acc  = accept && !start && (md_ctr == MD_MTLO);

    // Sign-extending to 64 bits lets one unsigned multiplier serve both forms
    assign mul_sgn = (ctr_q == MD_MULT);
    assign ext_a   = {{32{mul_sgn & a_q[31]}}, a_q};
    assign ext_b   = {{32{mul_sgn & b_q[31]}}, b_q};
    assign prod    = ext_a * ext_b;

`ifdef MDU_ITERATIVE_DIV_EN
    logic div_go;
    // Divider loads straight from the ports on the accept edge
    assign div_go = start_acc && md_ctr[1];

    mdu_div_seq u_div_seq (
        .clk       (clk),
        .reset_n   (reset_n),
        .go        (div_go),
        .signed_op (md_ctr == MD_DIV),
        .dividend  (op_a),
        .divisor   (op_b),
        .done      (div_done),
        .quot      (div_quot),
        .rem       (div_rem)
    );
`else
    logic [31:0] abs_a, abs_b, safe_b, q_mag, r_mag;
    logic        div_sgn, neg_q, neg_r;

    always_comb begin
        div_sgn = (ctr_q == MD_DIV);
        abs_a   = (div_sgn && a_q[31]) ? (32'd0 - a_q) : a_q;
        abs_b   = (div_sgn && b_q[31]) ? (32'd0 - b_q) : b_q;
        // Divide-by-zero result is discarded; keep the operator well defined
        safe_b  = (abs_b == 32'd0) ? 32'd1 : abs_b;
        q_mag   = abs_a / safe_b;
        r_mag   = abs_a % safe_b;
        neg_q   = div_sgn && (a_q[31] ^ b_q[31]);
        neg_r   = div_sgn && a_q[31];
        div_quot = neg_q ? (32'd0 - q_mag) : q_mag;
        div_rem  = neg_r ? (32'd0 - r_mag) : r_mag;
        div_done = 1'b1;
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctr_d   = ctr_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            IDLE: begin
                if (start_acc) begin
                    ctr_d   = md_ctr;
                    a_d     = op_a;
                    b_d     = op_b;
                    cnt_d   = md_ctr[1] ? CNT_W'(DIV_LAT) : CNT_W'(MULT_CYCLES);
                    state_d = RUN;
                end else if (mthi_acc) begin
                    hi_d = op_a;
                end else if (mtlo_acc) begin
                    lo_d = op_a;
                end
            end
            RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    if (!ctr_q[1]) begin
                        hi_d = prod[63:32];
                        lo_d = prod[31:0];
                    end else if ((b_q != 32'd0) && div_done) begin
                        hi_d = div_rem;
                        lo_d = div_quot;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ctr_q   <= 3'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctr_q   <= ctr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign stall_md = busy || (start && en_md && !cancel);
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed plus randomized bench for mult_div_unit with an arithmetic model.
// Latency: follows the DUT's per-op busy length.
// Backpressure: drives commands while busy to confirm they are dropped.
module tb_mult_div_unit;
    import mdu_pkg::*;

    localparam int MULT_LAT = 5;
`ifdef MDU_ITERATIVE_DIV_EN
    localparam int DIV_LAT = 33;
`else
    localparam int DIV_LAT = 10;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        en_md;
    logic [2:0]  md_ctr;
    logic        cancel;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    always #5 clk = ~clk;

    mult_div_unit dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .en_md    (en_md),
        .md_ctr   (md_ctr),
        .cancel   (cancel),
        .op_a     (op_a),
        .op_b     (op_b),
        .busy     (busy),
        .stall_md (stall_md),
        .hi       (hi),
        .lo       (lo)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        start  = 1'b0;
        en_md  = 1'b0;
        cancel = 1'b0;
        md_ctr = 3'd0;
    endtask

    // Architectural effect of one accepted command, from plain arithmetic.
    task automatic model(input logic [2:0] ctr, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (ctr)
            3'd0: begin p = 64'(sa * sb); exp_hi = p[63:32]; exp_lo = p[31:0]; end
            3'd1: begin p = {32'd0, a} * {32'd0, b}; exp_hi = p[63:32]; exp_lo = p[31:0]; end
            3'd2: if (b != 32'd0) begin
                      q = sa / sb;
                      r = sa % sb;
                      exp_lo = q[31:0];
                      exp_hi = r[31:0];
                  end
            3'd3: if (b != 32'd0) begin exp_lo = a / b; exp_hi = a % b; end
            3'd4: exp_hi = a;
            3'd5: exp_lo = a;
            default: ;
        endcase
    endtask

    task automatic run_op(input logic [2:0] ctr, input logic [31:0] a, input logic [31:0] b,
                          input bit intrude, input string tag);
        int          lat;
        int          n;
        bit          ok;
        logic [31:0] h0, l0;
        lat = ctr[1] ? DIV_LAT : MULT_LAT;
        h0  = exp_hi;
        l0  = exp_lo;
        idle_in();
        start = 1'b1; en_md = 1'b1; md_ctr = ctr; op_a = a; op_b = b;
        #1;
        chk({tag, " stall_at_start"}, 32'(stall_md), 32'd1);
        step();
        model(ctr, a, b);
        start = 1'b0; en_md = 1'b0; op_a = $urandom; op_b = $urandom;
        n  = 0;
        ok = 1'b1;
        while (busy === 1'b1 && n < 100) begin
            n++;
            if (hi !== h0 || lo !== l0 || stall_md !== 1'b1) ok = 1'b0;
            if (intrude && n == 1) begin
                en_md = 1'b1; md_ctr = MD_MTLO; op_a = 32'hDEADBEEF;
            end else if (intrude && n == 2) begin
                en_md = 1'b1; start = 1'b1; md_ctr = MD_DIVU; op_a = 32'd100; op_b = 32'd7;
            end else begin
                start = 1'b0; en_md = 1'b0; op_a = $urandom; op_b = $urandom;
            end
            step();
        end
        idle_in();
        chk({tag, " busy_cycles"}, 32'(n), 32'(lat));
        chk({tag, " hold_during_run"}, 32'(ok), 32'd1);
        chk({tag, " hi"}, hi, exp_hi);
        chk({tag, " lo"}, lo, exp_lo);
    endtask

    task automatic do_mt(input logic [2:0] ctr, input logic [31:0] val, input string tag);
        idle_in();
        en_md = 1'b1; md_ctr = ctr; op_a = val;
        #1;
        chk({tag, " stall"}, 32'(stall_md), 32'd0);
        step();
        idle_in();
        model(ctr, val, 32'd0);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " hi"}, hi, exp_hi);
        chk({tag, " lo"}, lo, exp_lo);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  rc;
        logic [31:0] ra, rb;

        reset_n = 1'b0;
        idle_in();
        op_a = 32'd0;
        op_b = 32'd0;
        repeat (2) step();
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        chk("reset stall", 32'(stall_md), 32'd0);
        reset_n = 1'b1;
        step();

        run_op(MD_MULT, 32'hFFFFFFFE, 32'd3, 1'b0, "mult");
        chk("mult hi const", hi, 32'hFFFFFFFF);
        chk("mult lo const", lo, 32'hFFFFFFFA);
        run_op(MD_MULTU, 32'hFFFFFFFE, 32'd3, 1'b0, "multu");
        chk("multu hi const", hi, 32'h00000002);
        chk("multu lo const", lo, 32'hFFFFFFFA);

        run_op(MD_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, "div");
        chk("div lo const", lo, 32'hFFFFFFFD);
        chk("div hi const", hi, 32'hFFFFFFFF);
        run_op(MD_DIVU, 32'd7, 32'd2, 1'b0, "divu");
        chk("divu lo const", lo, 32'd3);
        chk("divu hi const", hi, 32'd1);

        do_mt(MD_MTHI, 32'h12345678, "mthi");
        do_mt(MD_MTLO, 32'h9ABCDEF0, "mtlo");
        chk("mt hi const", hi, 32'h12345678);
        chk("mt lo const", lo, 32'h9ABCDEF0);

        run_op(MD_MULT, 32'h00012345, 32'hFFFF0003, 1'b1, "mult_intrude");

        do_mt(MD_MTHI, 32'hAAAA0000, "mthi_pre_dz");
        do_mt(MD_MTLO, 32'h0000BBBB, "mtlo_pre_dz");
        run_op(MD_DIVU, 32'h00001234, 32'd0, 1'b0, "divu_by_zero");
        chk("dz hi const", hi, 32'hAAAA0000);
        chk("dz lo const", lo, 32'h0000BBBB);
        run_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, "div_ovf");
        chk("ovf lo const", lo, 32'h80000000);
        chk("ovf hi const", hi, 32'h00000000);
        run_op(MD_DIV, 32'd9, 32'hFFFFFFFC, 1'b0, "div_pos_neg");

        // Cancelled start and cancelled mthi
        idle_in();
        start = 1'b1; en_md = 1'b1; cancel = 1'b1; md_ctr = MD_MULT;
        op_a = 32'd5; op_b = 32'd6;
        #1;
        chk("cancel stall", 32'(stall_md), 32'd0);
        step();
        chk("cancel busy", 32'(busy), 32'd0);
        chk("cancel hi", hi, exp_hi);
        chk("cancel lo", lo, exp_lo);
        start = 1'b0; md_ctr = MD_MTHI; op_a = 32'h55555555;
        step();
        chk("cancel mthi hi", hi, exp_hi);

        // Invalid encodings
        idle_in();
        en_md = 1'b1; md_ctr = 3'b110; op_a = 32'h0BADF00D;
        step();
        start = 1'b1; md_ctr = 3'b111;
        step();
        idle_in();
        chk("invalid busy", 32'(busy), 32'd0);
        chk("invalid hi", hi, exp_hi);
        chk("invalid lo", lo, exp_lo);

        // Randomized commands against the model
        for (int i = 0; i < 16; i++) begin
            rc = 3'($urandom_range(0, 5));
            ra = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1, 2:    rb = 32'($urandom_range(1, 9));
                3:       rb = 32'd0 - 32'($urandom_range(1, 9));
                default: rb = $urandom;
            endcase
            if (rc[2]) do_mt(rc, ra, "rand_mt");
            else       run_op(rc, ra, rb, 1'b0, "rand_op");
        end

        // Reset during the third busy cycle of a divide
        idle_in();
        start = 1'b1; en_md = 1'b1; md_ctr = MD_DIV; op_a = 32'd100; op_b = 32'd7;
        step();
        idle_in();
        step();
        step();
        reset_n = 1'b0;
        step();
        chk("rst_mid busy", 32'(busy), 32'd0);
        chk("rst_mid hi", hi, 32'd0);
        chk("rst_mid lo", lo, 32'd0);
        reset_n = 1'b1;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        repeat (DIV_LAT + 2) step();
        chk("rst_mid late busy", 32'(busy), 32'd0);
        chk("rst_mid late hi", hi, 32'd0);
        chk("rst_mid late lo", lo, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
